// File: rtl/fft_r2_sched_if.sv
// rtl/fft_r2_sched_if.sv - issue and write-back bus of the radix-2 FFT sequencer
interface fft_r2_sched_if #(
    parameter int LOG2N = 4
);
    localparam int SW = $clog2(LOG2N) + 1;

    logic             i_start;
    logic             o_busy;
    logic             o_done;
    logic             o_rd_en;
    logic [LOG2N-1:0] o_rd_addr_u;
    logic [LOG2N-1:0] o_rd_addr_v;
    logic [LOG2N-2:0] o_tw_addr;
    logic [SW-1:0]    o_stage;
    logic             o_wr_en;
    logic [LOG2N-1:0] o_wr_addr_u;
    logic [LOG2N-1:0] o_wr_addr_v;

    modport master (
        input  i_start,
        output o_busy, o_done, o_rd_en, o_rd_addr_u, o_rd_addr_v, o_tw_addr,
        output o_stage, o_wr_en, o_wr_addr_u, o_wr_addr_v
    );

    modport slave (
        output i_start,
        input  o_busy, o_done, o_rd_en, o_rd_addr_u, o_rd_addr_v, o_tw_addr,
        input  o_stage, o_wr_en, o_wr_addr_u, o_wr_addr_v
    );
endinterface

// File: rtl/fft_r2_sched.sv
// rtl/fft_r2_sched.sv - in-place radix-2 DIT FFT butterfly sequencer
module fft_r2_sched #(
    parameter int LOG2N    = 4,
    parameter int PIPE_LAT = 3
) (
    input  logic           i_clk,
    input  logic           i_rst,
    fft_r2_sched_if.master bus
);
    localparam int KW = LOG2N - 1;
    localparam int SW = $clog2(LOG2N) + 1;
    localparam int DW = 2 * LOG2N + 1;
    localparam logic [KW-1:0] K_LAST = '1;
    localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
    localparam logic [3:0]    LAT    = 4'(PIPE_LAT);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state_r, state_n;
    logic [KW-1:0] k_r, k_n;
    logic [SW-1:0] s_r, s_n;
    logic [3:0]    cnt_r, cnt_n;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= IDLE;
            k_r     <= '0;
            s_r     <= '0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_n;
            k_r     <= k_n;
            s_r     <= s_n;
            cnt_r   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state_r;
        k_n     = k_r;
        s_n     = s_r;
        cnt_n   = cnt_r;
        case (state_r)
            IDLE: if (bus.i_start) begin
                state_n = RUN;
                k_n     = '0;
                s_n     = '0;
            end
            RUN: if (k_r == K_LAST) begin
                state_n = DRAIN;
                cnt_n   = LAT;
            end else begin
                k_n = k_r + KW'(1);
            end
            DRAIN: if (cnt_r == 4'd1) begin
                if (s_r == S_LAST) begin
                    state_n = DONE;
                end else begin
                    state_n = RUN;
                    s_n     = s_r + SW'(1);
                    k_n     = '0;
                end
            end else begin
                cnt_n = cnt_r - 4'd1;
            end
            DONE: begin
                state_n = IDLE;
                k_n     = '0;
                s_n     = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are computed from the next state so they register alongside it.
    logic [LOG2N-1:0] half, kx, j, u, v;
    logic [SW-1:0]    tw_sh;
    logic             rd_en_n, busy_n, done_n;
    logic [LOG2N-1:0] u_n, v_n;
    logic [KW-1:0]    tw_n;
    logic [SW-1:0]    stage_n;

    always_comb begin
        half    = LOG2N'(1) << s_n;
        kx      = {1'b0, k_n};
        j       = kx & (half - LOG2N'(1));
        u       = ((kx >> s_n) << (s_n + SW'(1))) | j;
        v       = u | half;
        tw_sh   = S_LAST - s_n;
        rd_en_n = (state_n == RUN);
        busy_n  = (state_n != IDLE);
        done_n  = (state_n == DONE);
        u_n     = rd_en_n ? u : '0;
        v_n     = rd_en_n ? v : '0;
        // Group bits of k shift out past the top, leaving j << (LOG2N-1-s).
        tw_n    = rd_en_n ? (k_n << tw_sh) : '0;
        stage_n = rd_en_n ? s_n : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bus.o_busy      <= 1'b0;
            bus.o_done      <= 1'b0;
            bus.o_rd_en     <= 1'b0;
            bus.o_rd_addr_u <= '0;
            bus.o_rd_addr_v <= '0;
            bus.o_tw_addr   <= '0;
            bus.o_stage     <= '0;
        end else begin
            bus.o_busy      <= busy_n;
            bus.o_done      <= done_n;
            bus.o_rd_en     <= rd_en_n;
            bus.o_rd_addr_u <= u_n;
            bus.o_rd_addr_v <= v_n;
            bus.o_tw_addr   <= tw_n;
            bus.o_stage     <= stage_n;
        end
    end

    logic [DW-1:0] dl [PIPE_LAT];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < PIPE_LAT; i++) dl[i] <= '0;
        end else begin
            dl[0] <= {bus.o_rd_en, bus.o_rd_addr_u, bus.o_rd_addr_v};
            for (int i = 1; i < PIPE_LAT; i++) dl[i] <= dl[i-1];
        end
    end

    assign {bus.o_wr_en, bus.o_wr_addr_u, bus.o_wr_addr_v} = dl[PIPE_LAT-1];
endmodule

// File: tb/tb_fft_r2_sched.sv
// tb/tb_fft_r2_sched.sv - scoreboard bench for fft_r2_sched at LOG2N=3 and LOG2N=4
module tb_fft_r2_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   sel = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fft_r2_sched_if #(.LOG2N(3)) ifa ();
    fft_r2_sched_if #(.LOG2N(4)) ifb ();

    fft_r2_sched #(.LOG2N(3), .PIPE_LAT(3)) dut_a (.i_clk(clk), .i_rst(rst), .bus(ifa));
    fft_r2_sched #(.LOG2N(4), .PIPE_LAT(3)) dut_b (.i_clk(clk), .i_rst(rst), .bus(ifb));

    int o_busy, o_done, rd_en, ru, rv, tw, stg, wr_en, wu, wv;

    always_comb begin
        if (sel == 0) begin
            o_busy = int'(ifa.o_busy);      o_done = int'(ifa.o_done);
            rd_en  = int'(ifa.o_rd_en);     ru     = int'(ifa.o_rd_addr_u);
            rv     = int'(ifa.o_rd_addr_v); tw     = int'(ifa.o_tw_addr);
            stg    = int'(ifa.o_stage);     wr_en  = int'(ifa.o_wr_en);
            wu     = int'(ifa.o_wr_addr_u); wv     = int'(ifa.o_wr_addr_v);
        end else begin
            o_busy = int'(ifb.o_busy);      o_done = int'(ifb.o_done);
            rd_en  = int'(ifb.o_rd_en);     ru     = int'(ifb.o_rd_addr_u);
            rv     = int'(ifb.o_rd_addr_v); tw     = int'(ifb.o_tw_addr);
            stg    = int'(ifb.o_stage);     wr_en  = int'(ifb.o_wr_en);
            wu     = int'(ifb.o_wr_addr_u); wv     = int'(ifb.o_wr_addr_v);
        end
    end

    typedef struct { int cyc; int s; int u; int v; int tw; } rd_t;
    typedef struct { int cyc; int u; int v; } wr_t;
    rd_t exp_rd[$];
    wr_t exp_wr[$];

    task automatic drive_start(input int which, input logic val);
        if (which == 0) ifa.i_start = val;
        else            ifb.i_start = val;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ifa.o_busy, ifa.o_done, ifa.o_rd_en, ifa.o_rd_addr_u, ifa.o_rd_addr_v, ifa.o_tw_addr,
             ifa.o_stage, ifa.o_wr_en, ifa.o_wr_addr_u, ifa.o_wr_addr_v} !== '0)
            $display("FAIL reset_a: outputs not all zero (busy=%0b rd_en=%0b wr_en=%0b), want 0",
                     ifa.o_busy, ifa.o_rd_en, ifa.o_wr_en);
        else n_pass++;
        n_checks++;
        if ({ifb.o_busy, ifb.o_done, ifb.o_rd_en, ifb.o_rd_addr_u, ifb.o_rd_addr_v, ifb.o_tw_addr,
             ifb.o_stage, ifb.o_wr_en, ifb.o_wr_addr_u, ifb.o_wr_addr_v} !== '0)
            $display("FAIL reset_b: outputs not all zero (busy=%0b rd_en=%0b wr_en=%0b), want 0",
                     ifb.o_busy, ifb.o_rd_en, ifb.o_wr_en);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Full transform: push expected issues/writes, pulse start, pop on every strobe.
    task automatic test_run(input int which, input int lg, input int pl, input bit extra);
        int n, t0, t_done, nwr, nbusy, ndone, zero_err, lim;
        rd_t r;
        wr_t w;
        sel = which;
        n = 1 << lg;
        nwr = 0; nbusy = 0; ndone = 0; zero_err = 0;
        exp_rd.delete();
        exp_wr.delete();
        @(negedge clk);
        t0 = cyc;
        for (int s = 0; s < lg; s++) begin
            for (int k = 0; k < n / 2; k++) begin
                int half, jj, grp, uu;
                half = 1 << s;
                jj   = k % half;
                grp  = k / half;
                uu   = grp * 2 * half + jj;
                r = '{t0 + 1 + s * (n / 2 + pl) + k, s, uu, uu + half, jj * (1 << (lg - 1 - s))};
                exp_rd.push_back(r);
                w = '{r.cyc + pl, uu, uu + half};
                exp_wr.push_back(w);
            end
        end
        t_done = t0 + 1 + lg * (n / 2 + pl);
        drive_start(which, 1'b1);
        lim = t_done - t0 + 6;
        for (int c = 0; c < lim; c++) begin
            @(negedge clk);
            drive_start(which, extra && (cyc == t0 + 5 || cyc == t0 + 20 || cyc == t_done));
            if (o_busy != 0) nbusy++;
            if (rd_en != 0) begin
                n_checks++;
                if (exp_rd.size() == 0) begin
                    $display("FAIL rd_extra: issue at cyc %0d u=%0d v=%0d, want no issue", cyc - t0, ru, rv);
                end else begin
                    r = exp_rd.pop_front();
                    if (cyc !== r.cyc || stg !== r.s || ru !== r.u || rv !== r.v || tw !== r.tw)
                        $display("FAIL rd_issue: got t=%0d s=%0d u=%0d v=%0d tw=%0d, want t=%0d s=%0d u=%0d v=%0d tw=%0d",
                                 cyc - t0, stg, ru, rv, tw, r.cyc - t0, r.s, r.u, r.v, r.tw);
                    else n_pass++;
                end
            end
            if (wr_en != 0) begin
                nwr++;
                n_checks++;
                if (exp_wr.size() == 0) begin
                    $display("FAIL wr_extra: write at t=%0d u=%0d v=%0d, want none", cyc - t0, wu, wv);
                end else begin
                    w = exp_wr.pop_front();
                    if (cyc !== w.cyc || wu !== w.u || wv !== w.v)
                        $display("FAIL wr_back: got t=%0d u=%0d v=%0d, want t=%0d u=%0d v=%0d",
                                 cyc - t0, wu, wv, w.cyc - t0, w.u, w.v);
                    else n_pass++;
                end
            end else if (wu != 0 || wv != 0) begin
                zero_err++;
            end
            if (o_done != 0) begin
                ndone++;
                n_checks++;
                if (cyc !== t_done)
                    $display("FAIL done_time: got t=%0d, want t=%0d", cyc - t0, t_done - t0);
                else n_pass++;
            end
        end
        drive_start(which, 1'b0);
        n_checks++;
        if (exp_rd.size() != 0 || exp_wr.size() != 0)
            $display("FAIL missing: got %0d issues %0d writes outstanding, want 0 0", exp_rd.size(), exp_wr.size());
        else n_pass++;
        n_checks++;
        if (nwr !== lg * n / 2) $display("FAIL wr_count: got %0d, want %0d", nwr, lg * n / 2);
        else n_pass++;
        n_checks++;
        if (nbusy !== t_done - t0) $display("FAIL busy_len: got %0d, want %0d", nbusy, t_done - t0);
        else n_pass++;
        n_checks++;
        if (ndone !== 1) $display("FAIL done_count: got %0d, want 1", ndone);
        else n_pass++;
        n_checks++;
        if (zero_err !== 0) $display("FAIL wr_addr_idle: got %0d nonzero idle cycles, want 0", zero_err);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        bit found;
        int bad;
        sel = 0;
        found = 1'b0;
        bad = 0;
        @(negedge clk);
        drive_start(0, 1'b1);
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            drive_start(0, 1'b0);
            if (rd_en != 0 && stg == 1) found = 1'b1;
        end
        n_checks++;
        if (!found) $display("FAIL mid_stage1: got no stage-1 issue within 40 cycles, want one");
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({o_busy, o_done, rd_en, ru, rv, tw, stg, wr_en, wu, wv} !== '0)
            $display("FAIL mid_reset: got busy=%0d rd_en=%0d wr_en=%0d wu=%0d, want all 0", o_busy, rd_en, wr_en, wu);
        else n_pass++;
        repeat (20) begin
            @(negedge clk);
            if (o_busy != 0 || o_done != 0 || rd_en != 0 || wr_en != 0) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL post_reset_idle: got %0d active cycles, want 0", bad);
        else n_pass++;
    endtask

    initial begin
        ifa.i_start = 1'b0;
        ifb.i_start = 1'b0;
        test_reset();
        test_run(0, 3, 3, 1'b0);
        test_run(1, 4, 3, 1'b0);
        test_run(1, 4, 3, 1'b1);
        test_run(0, 3, 3, 1'b1);
        test_reset_mid_run();
        test_run(0, 3, 3, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
